// File: rtl/simple_uart_rx.sv
// simple_uart_rx: 8N1 serial receiver feeding a show-ahead byte FIFO.
// Define SIMPLE_UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module simple_uart_rx #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    input  logic [15:0] clkdiv,
    output logic [7:0]  fifo_out,
    input  logic        fifo_read,
    output logic [7:0]  fifo_level,
    output logic        fifo_empty,
    output logic        frame_err,
    output logic        overrun,
    output logic        parity_err
);

    localparam int unsigned ENTRIES = 1 << DEPTH;
    localparam int unsigned CNT_W   = DEPTH + 1;
    localparam int unsigned DIV_W   = 16;
    localparam int unsigned BIT_W   = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_e;

    // rx synchroniser; idles high so reset never looks like a start bit
    logic rx_meta_q;
    logic rxs_q;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] baud_ctr_q, baud_ctr_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             frame_err_q, frame_err_d;
    logic             wr_c;

`ifdef SIMPLE_UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             parity_err_q, parity_err_d;
`endif

    logic [7:0]       mem_q [ENTRIES];
    logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic [7:0]       last_q, last_d;
    logic             overrun_q, overrun_d;
    logic             full;
    logic             do_rd;
    logic             do_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // Frame state machine: next state, counters and byte completion strobe
    always_comb begin
        state_d     = state_q;
        baud_ctr_d  = baud_ctr_q + 16'd1;
        div_d       = div_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        wr_c        = 1'b0;
`ifdef SIMPLE_UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                baud_ctr_d = '0;
                if (!rxs_q) begin
                    state_d = S_START;
                    div_d   = clkdiv;
                end
            end
            S_START: begin
                if (baud_ctr_q == (div_q >> 1)) begin
                    baud_ctr_d = '0;
                    if (rxs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (baud_ctr_q == div_q) begin
                    baud_ctr_d = '0;
                    shift_d    = {rxs_q, shift_q[7:1]};
                    bit_idx_d  = BIT_W'(bit_idx_q + 3'd1);
                    if (bit_idx_q == 3'd7) begin
`ifdef SIMPLE_UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef SIMPLE_UART_RX_PARITY_EN
            S_PARITY: begin
                if (baud_ctr_q == div_q) begin
                    baud_ctr_d = '0;
                    par_d      = rxs_q;
                    state_d    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (baud_ctr_q == div_q) begin
                    baud_ctr_d = '0;
                    if (rxs_q) begin
                        state_d = S_IDLE;
`ifdef SIMPLE_UART_RX_PARITY_EN
                        if (^{par_q, shift_q}) begin
                            parity_err_d = 1'b1;
                        end else begin
                            wr_c = 1'b1;
                        end
`else
                        wr_c = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                baud_ctr_d = '0;
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                baud_ctr_d = '0;
                state_d    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            baud_ctr_q  <= '0;
            div_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_ctr_q  <= baud_ctr_d;
            div_q       <= div_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef SIMPLE_UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // FIFO bookkeeping; a read frees the slot a same-cycle write into a full FIFO needs
    always_comb begin
        full      = (count_q == CNT_W'(ENTRIES));
        do_rd     = fifo_read && (count_q != '0);
        do_wr     = wr_c && (!full || do_rd);
        overrun_d = wr_c && full && !do_rd;
        rd_ptr_d  = do_rd ? DEPTH'(rd_ptr_q + 1'b1) : rd_ptr_q;
        wr_ptr_d  = do_wr ? DEPTH'(wr_ptr_q + 1'b1) : wr_ptr_q;
        count_d   = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
        empty_d   = (count_d == '0);
        last_d    = do_rd ? mem_q[rd_ptr_q] : last_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            last_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // Show-ahead head; keeps presenting the last popped byte while empty
    assign fifo_out   = empty_q ? last_q : mem_q[rd_ptr_q];
    assign fifo_level = 8'(count_q);
    assign fifo_empty = empty_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_simple_uart_rx.sv
// Scoreboard bench for simple_uart_rx: frames are modelled as bit lists, expected bytes queued.
`timescale 1ns/1ps
module tb_simple_uart_rx;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ENTRIES = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] clkdiv = 16'd15;
    logic [7:0]  fifo_out;
    logic        fifo_read = 1'b0;
    logic [7:0]  fifo_level;
    logic        fifo_empty;
    logic        frame_err;
    logic        overrun;
    logic        parity_err;

    simple_uart_rx #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .clkdiv     (clkdiv),
        .fifo_out   (fifo_out),
        .fifo_read  (fifo_read),
        .fifo_level (fifo_level),
        .fifo_empty (fifo_empty),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    bit         drain_en = 1'b0;
    int         frame_err_cnt = 0;
    int         overrun_cnt = 0;
    int         parity_err_cnt = 0;
    int         cyc = 0;
    int         t_start = 0;
    int         t_fall = 0;
    logic       prev_empty = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: counts error pulses and pops/compares bytes whenever the FIFO presents one
    initial begin
        forever begin
            @(negedge clk);
            fifo_read = 1'b0;
            if (rst) begin
                if (frame_err)  frame_err_cnt++;
                if (overrun)    overrun_cnt++;
                if (parity_err) parity_err_cnt++;
                if (prev_empty && !fifo_empty) t_fall = cyc;
                prev_empty = fifo_empty;
                if (drain_en && !fifo_empty) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got 0x%0h with nothing expected", fifo_out);
                    end else begin
                        check("fifo_out", 32'(fifo_out), 32'(exp_q.pop_front()));
                    end
                    fifo_read = 1'b1;
                end
            end
        end
    end

    // Drive one frame; nbits < frame length truncates it (for mid-frame reset)
    task automatic send_frame(input logic [7:0] data, input int div, input bit stop,
                              input bit flip_par, input int nbits);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
`ifdef SIMPLE_UART_RX_PARITY_EN
        bits.push_back((^data) ^ flip_par);
`else
        if (flip_par) bits.push_back(1'b1);
`endif
        bits.push_back(stop);
        clkdiv = 16'(div);
        for (int i = 0; i < bits.size() && i < nbits; i++) begin
            @(negedge clk);
            if (i == 0) t_start = cyc;
            rx = bits[i];
            repeat (div) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || !fifo_empty) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        idle(3);
        check({name, "_drained"}, 32'(exp_q.size() == 0 && fifo_empty), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0;
        int ov0;
        int pe0;
        int lat;
        int div;
        logic [7:0] d;
        bit good;

        // reset values
        idle(2);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_out", 32'(fifo_out), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(5);

        // single frame, latency bound
        drain_en = 1'b0;
        send_frame(8'hA5, 15, 1'b1, 1'b0, 99);
        idle(4);
        lat = t_fall - t_start;
        check("latency_within_155", 32'(lat > 0 && lat <= 155), 32'd1);
        check("a5_out", 32'(fifo_out), 32'hA5);
        check("a5_level", 32'(fifo_level), 32'd1);
        exp_q.push_back(8'hA5);
        drain_en = 1'b1;
        wait_drain("a5");
        check("a5_level_after_pop", 32'(fifo_level), 32'd0);
        check("a5_hold_out", 32'(fifo_out), 32'hA5);

        // false start glitch
        drain_en = 1'b0;
        fe0 = frame_err_cnt;
        @(negedge clk);
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        check("glitch_level", 32'(fifo_level), 32'd0);
        check("glitch_no_frame_err", 32'(frame_err_cnt - fe0), 32'd0);
        drain_en = 1'b1;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 15, 1'b1, 1'b0, 99);
        wait_drain("3c");

        // bad stop bit then held-low line
        fe0 = frame_err_cnt;
        send_frame(8'h81, 15, 1'b0, 1'b0, 99);
        idle(40);
        rx = 1'b1;
        idle(40);
        check("break_one_frame_err", 32'(frame_err_cnt - fe0), 32'd1);
        check("break_fifo_empty", 32'(fifo_empty), 32'd1);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 15, 1'b1, 1'b0, 99);
        wait_drain("7e");

        // overflow: 17 frames into 16 entries
        drain_en = 1'b0;
        ov0 = overrun_cnt;
        fe0 = frame_err_cnt;
        for (int v = 0; v <= ENTRIES; v++) send_frame(8'(v), 7, 1'b1, 1'b0, 99);
        idle(20);
        check("ovf_level", 32'(fifo_level), 32'(ENTRIES));
        check("ovf_one_overrun", 32'(overrun_cnt - ov0), 32'd1);
        check("ovf_no_frame_err", 32'(frame_err_cnt - fe0), 32'd0);
        for (int v = 0; v < ENTRIES; v++) exp_q.push_back(8'(v));
        drain_en = 1'b1;
        wait_drain("ovf");

        // back-to-back loopback-style frames
        fe0 = frame_err_cnt;
        ov0 = overrun_cnt;
        pe0 = parity_err_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        send_frame(8'h00, 7, 1'b1, 1'b0, 99);
        send_frame(8'hFF, 7, 1'b1, 1'b0, 99);
        send_frame(8'h55, 7, 1'b1, 1'b0, 99);
        wait_drain("b2b");
        check("b2b_no_errors", 32'((frame_err_cnt - fe0) + (overrun_cnt - ov0) + (parity_err_cnt - pe0)), 32'd0);
`ifdef SIMPLE_UART_RX_PARITY_EN
        pe0 = parity_err_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 7, 1'b1, 1'b0, 99);
        send_frame(8'hFF, 7, 1'b1, 1'b0, 99);
        send_frame(8'h55, 7, 1'b1, 1'b1, 99);
        wait_drain("par");
        check("par_one_parity_err", 32'(parity_err_cnt - pe0), 32'd1);
`endif

        // randomized frames, occasional bad stop bit
        fe0 = frame_err_cnt;
        pe0 = 0;
        for (int k = 0; k < 24; k++) begin
            d    = 8'($urandom_range(0, 255));
            div  = int'($urandom_range(3, 12));
            good = ($urandom_range(0, 5) != 0);
            if (good) exp_q.push_back(d);
            else pe0++;
            send_frame(d, div, good, 1'b0, 99);
            rx = 1'b1;
            if (!good) idle(2 * (div + 1));
            idle(int'($urandom_range(0, 20)));
        end
        wait_drain("rand");
        check("rand_frame_errs", 32'(frame_err_cnt - fe0), 32'(pe0));

        // reset in the middle of a frame
        send_frame(8'h99, 15, 1'b1, 1'b0, 5);
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_empty", 32'(fifo_empty), 32'd1);
        check("mid_rst_out", 32'(fifo_out), 32'd0);
        check("mid_rst_errs", 32'({frame_err, overrun, parity_err}), 32'd0);
        rx = 1'b1;
        idle(2);
        rst = 1'b1;
        prev_empty = 1'b1;
        idle(5);
        drain_en = 1'b0;
        send_frame(8'h42, 15, 1'b1, 1'b0, 99);
        idle(200);
        check("post_rst_level", 32'(fifo_level), 32'd1);
        check("post_rst_out", 32'(fifo_out), 32'h42);
        exp_q.push_back(8'h42);
        drain_en = 1'b1;
        wait_drain("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
